// File: rtl/multi_countdown_core_if.sv
// rtl/multi_countdown_core_if.sv - control/status bundle between the panel front-end and the countdown core
interface multi_countdown_core_if #(
    parameter int NUM_CH = 4,
    parameter int DIGITS = 4,
    parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CW     = $clog2(DIGITS)
);
    logic                  tick;
    logic                  btn_up;
    logic                  btn_down;
    logic                  btn_left;
    logic                  btn_right;
    logic                  btn_start;
    logic                  modify;
    logic [CHW-1:0]        ch_sel;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic [CW-1:0]         cursor;
    logic [1:0]            state;
    logic [NUM_CH-1:0]     running;
    logic [NUM_CH-1:0]     done;

    modport master (
        output tick, btn_up, btn_down, btn_left, btn_right, btn_start, modify, ch_sel,
        input  disp_bcd, cursor, state, running, done
    );

    modport slave (
        input  tick, btn_up, btn_down, btn_left, btn_right, btn_start, modify, ch_sel,
        output disp_bcd, cursor, state, running, done
    );
endinterface

// File: rtl/multi_countdown_core.sv
// rtl/multi_countdown_core.sv - N-channel BCD countdown timer core with digit editing
// Optional AUTO_RELOAD_EN: channels reload their preset at zero and keep running.
module multi_countdown_core #(
    parameter int NUM_CH = 4,
    parameter int DIGITS = 4,
    parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CW     = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_countdown_core_if.slave bus
);
    localparam int VW = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } st_e;

    logic [VW-1:0]     value_q  [NUM_CH];
    logic [VW-1:0]     value_d  [NUM_CH];
    logic [VW-1:0]     preset_q [NUM_CH];
    logic [VW-1:0]     preset_d [NUM_CH];
    st_e               st_q     [NUM_CH];
    st_e               st_d     [NUM_CH];
    logic [CW-1:0]     cursor_q, cursor_d;
    logic [CHW-1:0]    ch_sel_q;
    logic [VW-1:0]     disp_q, disp_d;
    logic [1:0]        state_q, state_d;
    logic [NUM_CH-1:0] running_q, running_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] reload_pulse;

    // Borrow ripples from digit0 upward; digit1 borrows back to 5 (tens of seconds).
    function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (v[k*4 +: 4] == 4'd0) begin
                    r[k*4 +: 4] = (k == 1) ? 4'd5 : 4'd9;
                end else begin
                    r[k*4 +: 4] = v[k*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        int            sel_i;
        logic          start_sel;
        logic          sel_changed;
        logic [3:0]    dig;
        logic [3:0]    dig_max;
        logic [VW-1:0] dec;

        sel_i       = (32'(bus.ch_sel) < NUM_CH) ? int'(bus.ch_sel) : 0;
        start_sel   = bus.btn_start;
        sel_changed = (bus.ch_sel != ch_sel_q);
        cursor_d    = sel_changed ? '0 : cursor_q;
        dig         = '0;
        dig_max     = '0;
        dec         = '0;
        reload_pulse = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            value_d[i]  = value_q[i];
            preset_d[i] = preset_q[i];
            st_d[i]     = st_q[i];
            // A start on the selected running channel pre-empts its tick.
            if (st_q[i] == ST_RUN && bus.tick && !(start_sel && i == sel_i)) begin
                dec = (value_q[i] == '0) ? '0 : bcd_dec(value_q[i]);
                if (dec == '0) begin
`ifdef AUTO_RELOAD_EN
                    value_d[i]      = preset_q[i];
                    reload_pulse[i] = 1'b1;
`else
                    value_d[i] = '0;
                    st_d[i]    = ST_DONE;
`endif
                end else begin
                    value_d[i] = dec;
                end
            end
        end

        if (start_sel) begin
            case (st_q[sel_i])
                ST_IDLE: begin
                    if (value_q[sel_i] != '0) begin
                        preset_d[sel_i] = value_q[sel_i];
                        st_d[sel_i]     = ST_RUN;
                    end
                end
                ST_RUN:   st_d[sel_i] = ST_PAUSE;
                ST_PAUSE: st_d[sel_i] = ST_RUN;
                default: begin
                    value_d[sel_i] = preset_q[sel_i];
                    st_d[sel_i]    = ST_IDLE;
                end
            endcase
        end else if (bus.modify && !sel_changed &&
                     (st_q[sel_i] == ST_IDLE || st_q[sel_i] == ST_PAUSE)) begin
            dig     = value_q[sel_i][int'(cursor_q)*4 +: 4];
            dig_max = (cursor_q == CW'(1)) ? 4'd5 : 4'd9;
            if (bus.btn_up) begin
                value_d[sel_i][int'(cursor_q)*4 +: 4] = (dig >= dig_max) ? 4'd0 : dig + 4'd1;
            end else if (bus.btn_down) begin
                value_d[sel_i][int'(cursor_q)*4 +: 4] = (dig == 4'd0) ? dig_max : dig - 4'd1;
            end else if (bus.btn_left) begin
                cursor_d = (cursor_q == CW'(DIGITS - 1)) ? '0 : cursor_q + CW'(1);
            end else if (bus.btn_right) begin
                cursor_d = (cursor_q == '0) ? CW'(DIGITS - 1) : cursor_q - CW'(1);
            end
        end

        disp_d  = value_d[sel_i];
        state_d = st_d[sel_i];
        for (int i = 0; i < NUM_CH; i++) begin
            running_d[i] = (st_d[i] == ST_RUN);
`ifdef AUTO_RELOAD_EN
            done_d[i]    = reload_pulse[i];
`else
            done_d[i]    = (st_d[i] == ST_DONE);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                value_q[i]  <= '0;
                preset_q[i] <= '0;
                st_q[i]     <= ST_IDLE;
            end
            cursor_q  <= '0;
            ch_sel_q  <= '0;
            disp_q    <= '0;
            state_q   <= 2'b00;
            running_q <= '0;
            done_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                value_q[i]  <= value_d[i];
                preset_q[i] <= preset_d[i];
                st_q[i]     <= st_d[i];
            end
            cursor_q  <= cursor_d;
            ch_sel_q  <= bus.ch_sel;
            disp_q    <= disp_d;
            state_q   <= state_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.disp_bcd = disp_q;
    assign bus.cursor   = cursor_q;
    assign bus.state    = state_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
endmodule
